// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: groups the receiver handshake, host FIFO read port and
// status/interrupt signals of uart_rx_ctrl.
//   master : receiver + host side (drives rx_*, pop, clr_status, int_en)
//   slave  : uart_rx_ctrl (drives rx_ack, pop_*, empty, full, level, status, irq)
// DEPTH must match the DEPTH of the attached uart_rx_ctrl.
interface uart_rx_ctrl_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          rx_rdy;
   logic [7:0]    rx_data;
   logic          rx_perr;
   logic          rx_ferr;
   logic          rx_ack;
   logic          pop;
   logic [7:0]    pop_data;
   logic          pop_perr;
   logic          empty;
   logic          full;
   logic [LW-1:0] level;
   logic          overflow;
   logic          framing;
   logic          clr_status;
   logic          int_en;
   logic          irq;

   modport master (
      output rx_rdy, rx_data, rx_perr, rx_ferr, pop, clr_status, int_en,
      input  rx_ack, pop_data, pop_perr, empty, full, level, overflow, framing, irq
   );

   modport slave (
      input  rx_rdy, rx_data, rx_perr, rx_ferr, pop, clr_status, int_en,
      output rx_ack, pop_data, pop_perr, empty, full, level, overflow, framing, irq
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: captures bytes from a level-handshake UART receiver into a
// show-ahead FIFO, tracks sticky overflow/framing status and raises a
// registered interrupt.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : uart_rx_ctrl_if.slave (receiver handshake, host pop port, status, irq)
// DEPTH is a power of 2 in 2..64; THRESH is in 1..DEPTH.
module uart_rx_ctrl #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned THRESH = 4
) (
   input logic          clk,
   input logic          reset,
   uart_rx_ctrl_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StAck     = 2'd1;
   localparam logic [1:0] StWaitLow = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, framing_q, irq_q;
   logic [8:0]    mem [DEPTH];

   logic empty, full, capture, push, pop_eff, drop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LW'(DEPTH));
   assign capture = (state_q == StIdle) && bus.rx_rdy;
   assign pop_eff = bus.pop && !empty;
   // A full FIFO still accepts the byte when the host pops in the same cycle.
   assign push    = capture && (!full || bus.pop);
   assign drop    = capture && full && !bus.pop;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (bus.rx_rdy) state_d = StAck;
         StAck:     state_d = StWaitLow;
         StWaitLow: if (!bus.rx_rdy) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop_eff) begin
         level_d = level_q + LW'(1);
      end else if (!push && pop_eff) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         framing_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_eff) rd_ptr_q <= rd_ptr_q + PW'(1);
         // Set has priority over clear.
         if (drop) overflow_q <= 1'b1;
         else if (bus.clr_status) overflow_q <= 1'b0;
         if (bus.rx_ferr) framing_q <= 1'b1;
         else if (bus.clr_status) framing_q <= 1'b0;
         irq_q <= bus.int_en & ((level_q >= LW'(THRESH)) | overflow_q | framing_q);
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (!reset && push) mem[wr_ptr_q] <= {bus.rx_perr, bus.rx_data};
   end

   assign bus.rx_ack   = (state_q == StAck);
   assign bus.pop_data = mem[rd_ptr_q][7:0];
   assign bus.pop_perr = mem[rd_ptr_q][8];
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.level    = level_q;
   assign bus.overflow = overflow_q;
   assign bus.framing  = framing_q;
   assign bus.irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
   localparam int unsigned DEPTH = 8;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   ack_cnt;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;

   uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

   uart_rx_ctrl #(.DEPTH(DEPTH), .THRESH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every accepted pop is compared with the oldest expected entry.
   always @(negedge clk) begin
      if (bus.rx_ack) ack_cnt++;
      if (!reset && bus.pop && !bus.empty) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got 0x%0h expected no entry at %0t",
                     {bus.pop_perr, bus.pop_data}, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("pop_entry", {23'd0, bus.pop_perr, bus.pop_data}, {23'd0, mon_exp});
         end
      end
   end

   // Full receiver handshake; expect_push says whether the byte should land in the FIFO.
   task automatic send_byte(input logic [7:0] d, input logic p, input logic expect_push);
      int n;
      if (expect_push) exp_q.push_back({p, d});
      bus.rx_rdy  = 1'b1;
      bus.rx_data = d;
      bus.rx_perr = p;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.rx_ack && n < 8);
      check("rx_ack_seen", {31'd0, bus.rx_ack}, 32'd1);
      bus.rx_rdy = 1'b0;
      tick();
      tick();
   endtask

   task automatic pop_n(input int n);
      bus.pop = 1'b1;
      for (int i = 0; i < n; i++) tick();
      bus.pop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      ack_cnt = 0;
      reset = 1'b1;
      bus.rx_rdy = 1'b0;
      bus.rx_data = 8'h00;
      bus.rx_perr = 1'b0;
      bus.rx_ferr = 1'b0;
      bus.pop = 1'b0;
      bus.clr_status = 1'b0;
      bus.int_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_level", {28'd0, bus.level}, 32'd0);
      check("rst_empty", {31'd0, bus.empty}, 32'd1);
      check("rst_full", {31'd0, bus.full}, 32'd0);
      check("rst_rx_ack", {31'd0, bus.rx_ack}, 32'd0);
      check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      check("rst_framing", {31'd0, bus.framing}, 32'd0);
      check("rst_irq", {31'd0, bus.irq}, 32'd0);

      // Single byte 0x5A
      ack_cnt = 0;
      exp_q.push_back({1'b0, 8'h5A});
      bus.rx_rdy = 1'b1;
      bus.rx_data = 8'h5A;
      bus.rx_perr = 1'b0;
      tick();
      check("t1_level", {28'd0, bus.level}, 32'd1);
      check("t1_empty", {31'd0, bus.empty}, 32'd0);
      check("t1_rx_ack", {31'd0, bus.rx_ack}, 32'd1);
      bus.rx_rdy = 1'b0;
      tick();
      tick();
      tick();
      check("t1_ack_count", ack_cnt, 32'd1);
      check("t1_pop_data", {24'd0, bus.pop_data}, 32'h5A);
      pop_n(1);
      check("t1_empty_after_pop", {31'd0, bus.empty}, 32'd1);

      // Pop while empty is ignored
      pop_n(1);
      check("underflow_level", {28'd0, bus.level}, 32'd0);
      check("underflow_empty", {31'd0, bus.empty}, 32'd1);

      // Fill 0x00..0x07, then overflow with 0xFF
      for (int i = 0; i < 8; i++) send_byte(8'(i), i[0], 1'b1);
      check("t2_full", {31'd0, bus.full}, 32'd1);
      check("t2_level", {28'd0, bus.level}, 32'd8);
      check("t2_overflow_pre", {31'd0, bus.overflow}, 32'd0);
      ack_cnt = 0;
      send_byte(8'hFF, 1'b0, 1'b0);
      check("t2_overflow", {31'd0, bus.overflow}, 32'd1);
      check("t2_ack_count", ack_cnt, 32'd1);
      check("t2_level_after_drop", {28'd0, bus.level}, 32'd8);
      pop_n(8);
      check("t2_empty", {31'd0, bus.empty}, 32'd1);
      bus.clr_status = 1'b1;
      tick();
      bus.clr_status = 1'b0;
      check("t2_overflow_cleared", {31'd0, bus.overflow}, 32'd0);

      // Push 0xAA into a full FIFO with a same-cycle pop
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b1);
      exp_q.push_back({1'b1, 8'hAA});
      bus.rx_rdy = 1'b1;
      bus.rx_data = 8'hAA;
      bus.rx_perr = 1'b1;
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      bus.rx_rdy = 1'b0;
      check("t3_level", {28'd0, bus.level}, 32'd8);
      check("t3_overflow", {31'd0, bus.overflow}, 32'd0);
      tick();
      tick();
      tick();
      pop_n(8);
      check("t3_empty", {31'd0, bus.empty}, 32'd1);

      // IRQ at threshold 4
      bus.int_en = 1'b1;
      for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1'b0, 1'b1);
      check("t4_irq_below", {31'd0, bus.irq}, 32'd0);
      exp_q.push_back({1'b0, 8'h33});
      bus.rx_rdy = 1'b1;
      bus.rx_data = 8'h33;
      bus.rx_perr = 1'b0;
      tick();
      bus.rx_rdy = 1'b0;
      check("t4_level4", {28'd0, bus.level}, 32'd4);
      check("t4_irq_lat", {31'd0, bus.irq}, 32'd0);
      tick();
      check("t4_irq_set", {31'd0, bus.irq}, 32'd1);
      tick();
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      check("t4_irq_hold", {31'd0, bus.irq}, 32'd1);
      tick();
      check("t4_irq_drop", {31'd0, bus.irq}, 32'd0);
      pop_n(3);
      check("t4_empty", {31'd0, bus.empty}, 32'd1);
      bus.int_en = 1'b0;

      // Framing set beats a coincident clear
      bus.rx_ferr = 1'b1;
      bus.clr_status = 1'b1;
      tick();
      bus.rx_ferr = 1'b0;
      bus.clr_status = 1'b0;
      check("t5_framing_set", {31'd0, bus.framing}, 32'd1);
      bus.clr_status = 1'b1;
      tick();
      bus.clr_status = 1'b0;
      check("t5_framing_clr", {31'd0, bus.framing}, 32'd0);

      // Reset during ACK, then recapture
      bus.int_en = 1'b1;
      bus.rx_rdy = 1'b1;
      bus.rx_data = 8'hC3;
      bus.rx_perr = 1'b0;
      tick();
      check("t6_in_ack", {31'd0, bus.rx_ack}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_rx_ack", {31'd0, bus.rx_ack}, 32'd0);
      check("t6_rst_level", {28'd0, bus.level}, 32'd0);
      check("t6_rst_empty", {31'd0, bus.empty}, 32'd1);
      check("t6_rst_full", {31'd0, bus.full}, 32'd0);
      check("t6_rst_overflow", {31'd0, bus.overflow}, 32'd0);
      check("t6_rst_framing", {31'd0, bus.framing}, 32'd0);
      check("t6_rst_irq", {31'd0, bus.irq}, 32'd0);
      ack_cnt = 0;
      send_byte(8'hC3, 1'b0, 1'b1);
      check("t6_ack_count", ack_cnt, 32'd1);
      check("t6_level", {28'd0, bus.level}, 32'd1);
      pop_n(1);
      bus.int_en = 1'b0;
      tick();
      tick();
      check("sb_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
